// File: rtl/dot_product_streamer_pkg.sv
// Shared FSM encoding and float-format defaults for the dot-product streamer.
package dot_product_streamer_pkg;

    localparam int FRAC_WIDTH_DEF = 24;
    localparam int EXP_WIDTH_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_WAIT_RES,
        ST_DONE
    } state_t;

    function automatic int data_width(input int frac_w, input int exp_w);
        return frac_w + exp_w;
    endfunction

endpackage

// File: rtl/dot_product_streamer_if.sv
// Operand-RAM read ports and MAC beat/result ports; master is the streamer side.
interface dot_product_streamer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int VECTOR_SIZE = 8,
    parameter int ADDR_WIDTH  = 12
);
    logic                              memAEnOut;
    logic [ADDR_WIDTH-1:0]             memAAddrOut;
    logic [DATA_WIDTH*VECTOR_SIZE-1:0] memADataIn;
    logic                              memBEnOut;
    logic [ADDR_WIDTH-1:0]             memBAddrOut;
    logic [DATA_WIDTH*VECTOR_SIZE-1:0] memBDataIn;
    logic [DATA_WIDTH*VECTOR_SIZE-1:0] macDataAOut;
    logic [DATA_WIDTH*VECTOR_SIZE-1:0] macDataBOut;
    logic [VECTOR_SIZE-1:0]            macValidOut;
    logic                              macLastOut;
    logic [DATA_WIDTH-1:0]             macResultIn;
    logic                              macResultValidIn;

    modport master (
        output memAEnOut, memAAddrOut, memBEnOut, memBAddrOut,
        output macDataAOut, macDataBOut, macValidOut, macLastOut,
        input  memADataIn, memBDataIn, macResultIn, macResultValidIn
    );

    modport slave (
        input  memAEnOut, memAAddrOut, memBEnOut, memBAddrOut,
        input  macDataAOut, macDataBOut, macValidOut, macLastOut,
        output memADataIn, memBDataIn, macResultIn, macResultValidIn
    );
endinterface

// File: rtl/dot_product_streamer_delay.sv
// Fixed-latency register pipeline, synchronous active-low clear.
// Latency LATENCY cycles; no backpressure, accepts a word every cycle.
module dot_product_streamer_delay #(
    parameter int DATA_WIDTH = 1,
    parameter int LATENCY    = 1
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic [DATA_WIDTH-1:0] i_dat,
    output logic [DATA_WIDTH-1:0] o_dat
);
    logic [DATA_WIDTH-1:0] r_pipe [LATENCY];

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_dat;
            for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_dat = r_pipe[LATENCY-1];
endmodule

// File: rtl/dot_product_streamer.sv
// Reads two operand vectors from RAM, streams them to the MAC as masked beats, returns the scalar.
// First beat two cycles after start; one beat per cycle with no MAC backpressure.
module dot_product_streamer
    import dot_product_streamer_pkg::*;
#(
    parameter int FRAC_WIDTH  = FRAC_WIDTH_DEF,
    parameter int EXP_WIDTH   = EXP_WIDTH_DEF,
    parameter int VECTOR_SIZE = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int LEN_WIDTH   = 16,
    localparam int DATA_WIDTH = data_width(FRAC_WIDTH, EXP_WIDTH)
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  startIn,
    input  logic [ADDR_WIDTH-1:0] baseAIn,
    input  logic [ADDR_WIDTH-1:0] baseBIn,
    input  logic [LEN_WIDTH-1:0]  lengthIn,
    output logic                  busyOut,
    output logic                  doneOut,
    output logic [DATA_WIDTH-1:0] resultOut,
    dot_product_streamer_if.master bus
);
    localparam int LANE_W = $clog2(VECTOR_SIZE);
    localparam int BEAT_W = LEN_WIDTH - LANE_W + 1;
    localparam int BUS_W  = DATA_WIDTH * VECTOR_SIZE;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_base_a, r_base_b;
    logic [BEAT_W-1:0]       r_beat, r_nbeats;
    logic [LANE_W-1:0]       r_rem;
    logic [DATA_WIDTH-1:0]   r_result;

    logic                    w_accept, w_issue, w_last_beat, w_mac_last;
    logic [LEN_WIDTH:0]      w_len_rnd;
    logic [BEAT_W-1:0]       w_nbeats;
    logic [VECTOR_SIZE-1:0]  w_mask, w_lane_vld;
    logic [VECTOR_SIZE:0]    w_dly_in, w_dly_out;
    logic [BUS_W-1:0]        w_mac_a, w_mac_b;

    assign w_accept    = (r_state == ST_IDLE) && startIn;
    assign w_issue     = (r_state == ST_ISSUE);
    assign w_last_beat = (r_beat == (r_nbeats - BEAT_W'(1)));
    // Extra top bit keeps the round-up from overflowing at the maximum length.
    assign w_len_rnd   = {1'b0, lengthIn} + (LEN_WIDTH+1)'(VECTOR_SIZE - 1);
    assign w_nbeats    = w_len_rnd[LEN_WIDTH:LANE_W];
    assign w_mask      = (w_last_beat && r_rem != '0) ? ~({VECTOR_SIZE{1'b1}} << r_rem)
                                                      : {VECTOR_SIZE{1'b1}};

    always_ff @(posedge clkIn) begin
        if (!rstIn) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (startIn) w_state_nxt = (lengthIn == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE:    if (w_last_beat) w_state_nxt = ST_DRAIN;
            ST_DRAIN:    w_state_nxt = ST_WAIT_RES;
            ST_WAIT_RES: if (bus.macResultValidIn) w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            r_base_a <= '0;
            r_base_b <= '0;
            r_beat   <= '0;
            r_nbeats <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_base_a <= baseAIn;
                r_base_b <= baseBIn;
                r_rem    <= lengthIn[LANE_W-1:0];
                r_nbeats <= w_nbeats;
                r_beat   <= '0;
                r_result <= '0;
            end else if (w_issue) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
            if (r_state == ST_WAIT_RES && bus.macResultValidIn) r_result <= bus.macResultIn;
        end
    end

    // Mask and last travel one register behind the RAM read to meet the returning data.
    assign w_dly_in = w_issue ? {w_last_beat, w_mask} : '0;

    dot_product_streamer_delay #(
        .DATA_WIDTH (VECTOR_SIZE + 1),
        .LATENCY    (1)
    ) u_align (
        .clkIn (clkIn),
        .rstIn (rstIn),
        .i_dat (w_dly_in),
        .o_dat (w_dly_out)
    );

    assign {w_mac_last, w_lane_vld} = w_dly_out;

    always_comb begin
        w_mac_a = '0;
        w_mac_b = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            if (w_lane_vld[i]) begin
                w_mac_a[i*DATA_WIDTH +: DATA_WIDTH] = bus.memADataIn[i*DATA_WIDTH +: DATA_WIDTH];
                w_mac_b[i*DATA_WIDTH +: DATA_WIDTH] = bus.memBDataIn[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.memAEnOut   = w_issue;
    assign bus.memBEnOut   = w_issue;
    assign bus.memAAddrOut = w_issue ? r_base_a + ADDR_WIDTH'(r_beat) : '0;
    assign bus.memBAddrOut = w_issue ? r_base_b + ADDR_WIDTH'(r_beat) : '0;
    assign bus.macDataAOut = w_mac_a;
    assign bus.macDataBOut = w_mac_b;
    assign bus.macValidOut = w_lane_vld;
    assign bus.macLastOut  = w_mac_last;

    assign busyOut   = (r_state != ST_IDLE);
    assign doneOut   = (r_state == ST_DONE);
    assign resultOut = r_result;
endmodule
